// File: rtl/alu_pkg.sv
// Shared types and width defaults for the round-robin ALU arbiter.
`default_nettype none

package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SEL_W_DEF  = 3;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    NOT = 3'b101,
    SHL = 3'b110,
    SHR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_rr_arbiter_if.sv
// Requester handshake and ALU operand/result bundle for alu_rr_arbiter.
`default_nettype none

interface alu_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 3
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*SEL_W-1:0]  req_sel;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_zero;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [SEL_W-1:0]          alu_sel;
  logic [DATA_W-1:0]         alu_out;
  logic                      alu_zero;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, alu_out, alu_zero,
    output req_ready, rsp_valid, rsp_data, rsp_zero, alu_a, alu_b, alu_sel
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, alu_out, alu_zero,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, alu_a, alu_b, alu_sel
  );

endinterface

`default_nettype wire

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid requester after i_ptr, wrapping.
// ALU_ARB_PRIO_EN: requester 0 always wins and is excluded from the rotation.
`default_nettype none

module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_any_valid
);

  logic [NUM_REQ-1:0] w_rr_valid;
  logic               w_found;
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W-1:0]   w_cand;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int off);
    int s;
    s = (int'(p) + off) % NUM_REQ;
    return IDX_W'(s);
  endfunction

`ifdef ALU_ARB_PRIO_EN
  assign w_rr_valid = {i_valid[NUM_REQ-1:1], 1'b0};
`else
  assign w_rr_valid = i_valid;
`endif

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = wrap_idx(i_ptr, off);
      if (!w_found && w_rr_valid[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
`ifdef ALU_ARB_PRIO_EN
    if (i_valid[0]) begin
      w_found = 1'b1;
      w_sel   = '0;
    end
`endif
    o_any_valid = w_found;
    o_gnt_idx   = w_sel;
    o_gnt       = w_found ? (NUM_REQ'(1) << w_sel) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters with round-robin grant.
// Optional macro ALU_ARB_PRIO_EN gives requester 0 absolute priority.
`default_nettype none

module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_rr_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [IDX_W-1:0] c_ptr_rst  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ALU_LAT - 1);

  arb_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]  r_alu_a, w_alu_a_nxt;
  logic [DATA_W-1:0]  r_alu_b, w_alu_b_nxt;
  logic [SEL_W-1:0]   r_alu_sel, w_alu_sel_nxt;
  logic               w_accept;

  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_valid     (bus.req_valid),
    .i_ptr       (r_ptr),
    .o_gnt       (w_pick_gnt),
    .o_gnt_idx   (w_pick_idx),
    .o_any_valid (w_pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= c_ptr_rst;
      r_gnt_idx <= '0;
      r_cnt     <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_alu_a   <= w_alu_a_nxt;
      r_alu_b   <= w_alu_b_nxt;
      r_alu_sel <= w_alu_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gnt_idx_nxt = r_gnt_idx;
    w_cnt_nxt     = r_cnt;
    w_alu_a_nxt   = r_alu_a;
    w_alu_b_nxt   = r_alu_b;
    w_alu_sel_nxt = r_alu_sel;
    w_accept      = 1'b0;
    case (r_state)
      IDLE: begin
        // Gating on rst_n keeps ready low while reset is held.
        if (w_pick_any && rst_n) begin
          w_accept      = 1'b1;
          w_gnt_idx_nxt = w_pick_idx;
          w_cnt_nxt     = '0;
          w_alu_a_nxt   = bus.req_a[int'(w_pick_idx)*DATA_W +: DATA_W];
          w_alu_b_nxt   = bus.req_b[int'(w_pick_idx)*DATA_W +: DATA_W];
          w_alu_sel_nxt = bus.req_sel[int'(w_pick_idx)*SEL_W +: SEL_W];
          w_state_nxt   = EXEC;
`ifdef ALU_ARB_PRIO_EN
          if (w_pick_idx != '0) begin
            w_ptr_nxt = w_pick_idx;
          end
`else
          w_ptr_nxt = w_pick_idx;
`endif
        end
      end
      EXEC: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == c_cnt_last) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.req_ready = w_accept ? w_pick_gnt : '0;
  assign bus.rsp_valid = (r_state == RESP) ? (NUM_REQ'(1) << r_gnt_idx) : '0;
  assign bus.rsp_data  = (r_state == RESP) ? bus.alu_out : '0;
  assign bus.rsp_zero  = (r_state == RESP) & bus.alu_zero;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_sel   = r_alu_sel;

endmodule

`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter with a registered 8-bit ALU model attached.
`default_nettype none

module tb_alu_rr_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int SEL_W   = 3;
  localparam int ALU_LAT = 1;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
  } op_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       zero;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  op_t        req_q [NUM_REQ][$];
  exp_t       sb[$];
  int         gnt_log[$];
  int         gnt_cyc[$];
  int         rsp_idx[$];
  logic [7:0] rsp_dat[$];
  logic       rsp_zf[$];
  int         rsp_lat[$];

  alu_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  alu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .SEL_W   (SEL_W),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    case (s)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      NOT:     return ~a;
      SHL:     return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  always @(posedge clk) begin
    bus.alu_out  <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);
    bus.alu_zero <= (alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel) == 8'h00);
  end

  function automatic bit pending();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_q[i].size() > 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_q[i].size() > 0) begin
        bus.req_valid[i]                    = 1'b1;
        bus.req_a[i*DATA_W +: DATA_W]       = req_q[i][0].a;
        bus.req_b[i*DATA_W +: DATA_W]       = req_q[i][0].b;
        bus.req_sel[i*SEL_W +: SEL_W]       = req_q[i][0].sel;
      end else begin
        bus.req_valid[i]                    = 1'b0;
        bus.req_a[i*DATA_W +: DATA_W]       = '0;
        bus.req_b[i*DATA_W +: DATA_W]       = '0;
        bus.req_sel[i*SEL_W +: SEL_W]       = '0;
      end
    end
  endtask

  task automatic clear_logs();
    sb.delete();
    gnt_log.delete();
    gnt_cyc.delete();
    rsp_idx.delete();
    rsp_dat.delete();
    rsp_zf.delete();
    rsp_lat.delete();
  endtask

  // One clock: sample at negedge (handshakes, responses), update requesters after posedge.
  task automatic step();
    logic [NUM_REQ-1:0] hs;
    logic [NUM_REQ-1:0] exp_oh;
    op_t                op;
    exp_t               e;
    logic [7:0]         r;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      hs = bus.req_valid & bus.req_ready;
      n_tests++;
      if ($countones(bus.req_ready) > 1 || (bus.req_ready & ~bus.req_valid) != '0) begin
        n_fail++;
        $display("FAIL ready_onehot: req_ready=%b req_valid=%b", bus.req_ready, bus.req_valid);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i]) begin
          op = req_q[i].pop_front();
          r  = alu_fn(op.a, op.b, op.sel);
          e.idx = i; e.data = r; e.zero = (r == 8'h00); e.cyc = cyc;
          sb.push_back(e);
          gnt_log.push_back(i);
          gnt_cyc.push_back(cyc);
        end
      end
      n_tests++;
      if (bus.rsp_valid != '0) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding", bus.rsp_valid);
        end else begin
          e = sb.pop_front();
          exp_oh = NUM_REQ'(1) << e.idx;
          rsp_idx.push_back(e.idx);
          rsp_dat.push_back(bus.rsp_data);
          rsp_zf.push_back(bus.rsp_zero);
          rsp_lat.push_back(cyc - e.cyc);
          if (bus.rsp_valid !== exp_oh || bus.rsp_data !== e.data || bus.rsp_zero !== e.zero
              || (cyc - e.cyc) != ALU_LAT + 1) begin
            n_fail++;
            $display("FAIL sb_rsp: got valid=%b data=%h zero=%b lat=%0d, expected valid=%b data=%h zero=%b lat=%0d",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_zero, cyc - e.cyc,
                     exp_oh, e.data, e.zero, ALU_LAT + 1);
          end
        end
      end else if (bus.rsp_data !== 8'h00 || bus.rsp_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL rsp_idle: rsp_data=%h rsp_zero=%b, expected 00/0", bus.rsp_data, bus.rsp_zero);
      end
    end
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n;
    n = 0;
    drive_inputs();
    while ((pending() || sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    n_tests++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d cycles used, limit %0d", name, n, budget);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_REQ; i++) req_q[i].delete();
    drive_inputs();
    rst_n = 1'b0;
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_order(input string name, input int exp_q[$]);
    n_tests++;
    if (gnt_log.size() < exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: %0d grants, expected at least %0d", name, gnt_log.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_tests++;
        if (gnt_log[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL %s_grant%0d: got req%0d, expected req%0d", name, k, gnt_log[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_a = '1; bus.req_b = '1; bus.req_sel = '1;
    #2;
    n_tests++;
    if (bus.req_ready !== 4'h0) begin
      n_fail++; $display("FAIL reset_ready: got %b, expected 0000", bus.req_ready);
    end
    n_tests++;
    if (bus.rsp_valid !== 4'h0 || bus.rsp_data !== 8'h00 || bus.rsp_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: got %b/%h/%b, expected 0000/00/0", bus.rsp_valid, bus.rsp_data, bus.rsp_zero);
    end
    n_tests++;
    if (bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00 || bus.alu_sel !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_alu: got %h/%h/%b, expected 00/00/000", bus.alu_a, bus.alu_b, bus.alu_sel);
    end
    do_reset();
  endtask

  task automatic test_single_add();
    op_t op;
    do_reset();
    op.a = 8'd10; op.b = 8'd5; op.sel = ADD;
    req_q[0].push_back(op);
    run_until_done(20, "single_add");
    check_order("single_add", '{0});
    n_tests++;
    if (rsp_dat.size() != 1 || rsp_dat[0] !== 8'd15 || rsp_zf[0] !== 1'b0 || rsp_idx[0] != 0 || rsp_lat[0] != 2) begin
      n_fail++;
      $display("FAIL single_add_rsp: got %0d rsps first data=%0d, expected 1 rsp data=15 zero=0 req0 lat=2",
               rsp_dat.size(), (rsp_dat.size() > 0) ? rsp_dat[0] : 8'hxx);
    end
  endtask

  task automatic test_all_valid();
    op_t op;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      op.a = 8'(i + 1); op.b = 8'd1; op.sel = ADD;
      req_q[i].push_back(op);
    end
    run_until_done(40, "all_valid");
    check_order("all_valid", '{0, 1, 2, 3});
    n_tests++;
    if (gnt_cyc.size() != 4 || rsp_dat.size() != 4) begin
      n_fail++;
      $display("FAIL all_valid_sizes: got %0d grants %0d rsps, expected 4/4", gnt_cyc.size(), rsp_dat.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (gnt_cyc[k] - gnt_cyc[0] != 3 * k || rsp_idx[k] != k || rsp_dat[k] !== 8'(k + 2)) begin
          n_fail++;
          $display("FAIL all_valid_op%0d: got offset=%0d req=%0d data=%0d, expected offset=%0d req=%0d data=%0d",
                   k, gnt_cyc[k] - gnt_cyc[0], rsp_idx[k], rsp_dat[k], 3 * k, k, k + 2);
        end
      end
    end
  endtask

  task automatic test_two_requesters();
    op_t op;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      op.a = 8'(16 * k + 1); op.b = 8'(k); op.sel = XOR;
      req_q[1].push_back(op);
      op.a = 8'(16 * k + 3); op.b = 8'(k + 7); op.sel = OR;
      req_q[3].push_back(op);
    end
    run_until_done(40, "pair_1_3");
    check_order("pair_1_3", '{1, 3, 1, 3, 1, 3});
  endtask

  task automatic test_zero_flag();
    op_t op;
    do_reset();
    op.a = 8'd5; op.b = 8'd5; op.sel = SUB;
    req_q[2].push_back(op);
    op.a = 8'h0F; op.b = 8'h00; op.sel = NOT;
    req_q[2].push_back(op);
    run_until_done(20, "zero_flag");
    n_tests++;
    if (rsp_dat.size() != 2 || rsp_idx[0] != 2 || rsp_dat[0] !== 8'h00 || rsp_zf[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_zero: got %0d rsps first data=%h zero=%b, expected req2 data=00 zero=1",
               rsp_dat.size(), (rsp_dat.size() > 0) ? rsp_dat[0] : 8'hxx, (rsp_zf.size() > 0) ? rsp_zf[0] : 1'bx);
    end else begin
      n_tests++;
      if (rsp_dat[1] !== 8'hF0 || rsp_zf[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL not_result: got data=%h zero=%b, expected F0/0", rsp_dat[1], rsp_zf[1]);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    op_t op;
    int  n;
    do_reset();
    op.a = 8'd7; op.b = 8'd9; op.sel = ADD;
    req_q[3].push_back(op);
    drive_inputs();
    n = 0;
    while (gnt_log.size() == 0 && n < 10) begin
      step();
      n++;
    end
    n_tests++;
    if (gnt_log.size() == 0) begin
      n_fail++; $display("FAIL midreset_accept: no grant for req3 within 10 cycles");
    end
    // Now one cycle into EXEC: pull reset and drop the in-flight op.
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.rsp_valid !== 4'h0 || bus.alu_a !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_clear: got rsp_valid=%b alu_a=%h, expected 0000/00", bus.rsp_valid, bus.alu_a);
    end
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step();
    op.a = 8'd1; op.b = 8'd2; op.sel = AND;
    req_q[0].push_back(op);
    op.a = 8'd3; op.b = 8'd4; op.sel = ADD;
    req_q[3].push_back(op);
    run_until_done(30, "post_reset");
    check_order("post_reset", '{0, 3});
  endtask

  task automatic test_priority();
    op_t op;
    int  exp_q[$];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      op.a = 8'(k + 20); op.b = 8'(k); op.sel = SUB;
      req_q[0].push_back(op);
      op.a = 8'(k + 40); op.b = 8'(k); op.sel = ADD;
      req_q[2].push_back(op);
    end
`ifdef ALU_ARB_PRIO_EN
    exp_q = '{0, 0, 0, 2};
`else
    exp_q = '{0, 2, 0, 2};
`endif
    run_until_done(40, "prio");
    check_order("prio", exp_q);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    test_reset();
    test_single_add();
    test_all_valid();
    test_two_requesters();
    test_zero_flag();
    test_reset_mid_exec();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
